// File: rtl/iec_listener.sv
// IEC serial bus listener: ATN handling, command decode for its own device
// number, LSB-first byte reception with EOI detection and frame acknowledge.
// Received bytes go to the device core as single-cycle valid strobes.
module iec_listener #(
   parameter int DEVICE         = 8,
   parameter int CLKS_PER_US    = 8,
   parameter int EOI_TIMEOUT_US = 200,
   parameter int EOI_HOLD_US    = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       atn_i,
   input  logic       clock_i,
   input  logic       data_i,
   output logic       data_o,
   output logic       clock_o,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_eoi,
   output logic       rx_atn,
   input  logic       rx_ready,
   output logic       listening,
   output logic       talking,
   output logic [3:0] channel,
   output logic [3:0] sec_cmd
);

   localparam logic [15:0] EOI_TICKS  = 16'(EOI_TIMEOUT_US * CLKS_PER_US);
   localparam logic [15:0] HOLD_TICKS = 16'(EOI_HOLD_US * CLKS_PER_US);
   localparam logic [4:0]  DEV        = 5'(DEVICE);
   localparam logic [7:0]  LISTEN_CMD = {3'b001, DEV};

   typedef enum logic [2:0] {
      IDLE, WAIT_REL, READY, EOI_ACK, EOI_WAIT, BIT_LO, BIT_HI, ACK
   } state_t;

   state_t      state_reg;
   logic [2:0]  sync1_reg;
   logic [2:0]  sync2_reg;
   logic        atn_prev_reg;
   logic        clk_prev_reg;
   logic        atn_mode_reg;
   logic        eoi_reg;
   logic [3:0]  bit_cnt_reg;
   logic [7:0]  shift_reg;
   logic [15:0] timer_reg;

   logic atn_s, clk_s, dat_s;
   logic atn_fall, atn_rise, clk_rise, clk_fall;

   assign atn_s    = sync2_reg[2];
   assign clk_s    = sync2_reg[1];
   assign dat_s    = sync2_reg[0];
   assign atn_fall = atn_prev_reg & ~atn_s;
   assign atn_rise = ~atn_prev_reg & atn_s;
   assign clk_rise = ~clk_prev_reg & clk_s;
   assign clk_fall = clk_prev_reg & ~clk_s;

   // This block only listens; the CLK line is never pulled.
   assign clock_o = 1'b1;

   // Two-flop synchronizers for ATN, CLK and DATA; idle lines read as high.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg <= 3'b111;
         sync2_reg <= 3'b111;
      end else begin
         sync1_reg <= {atn_i, clock_i, data_i};
         sync2_reg <= sync1_reg;
      end
   end

   // Bus protocol FSM with registered DATA drive, receive strobe and address flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         data_o       <= 1'b1;
         rx_data      <= 8'h00;
         rx_valid     <= 1'b0;
         rx_eoi       <= 1'b0;
         rx_atn       <= 1'b0;
         listening    <= 1'b0;
         talking      <= 1'b0;
         channel      <= 4'h0;
         sec_cmd      <= 4'h0;
         atn_prev_reg <= 1'b1;
         clk_prev_reg <= 1'b1;
         atn_mode_reg <= 1'b0;
         eoi_reg      <= 1'b0;
         bit_cnt_reg  <= 4'd0;
         shift_reg    <= 8'h00;
         timer_reg    <= 16'd0;
      end else begin
         atn_prev_reg <= atn_s;
         clk_prev_reg <= clk_s;
         rx_valid     <= 1'b0;

         if (atn_fall) begin
            // Controller takes the bus: drop any partial byte and acknowledge ATN.
            atn_mode_reg <= 1'b1;
            bit_cnt_reg  <= 4'd0;
            state_reg    <= WAIT_REL;
            data_o       <= 1'b0;
         end else if (atn_rise) begin
            atn_mode_reg <= 1'b0;
            bit_cnt_reg  <= 4'd0;
            if (listening) begin
               state_reg <= WAIT_REL;
               data_o    <= 1'b0;
            end else begin
               state_reg <= IDLE;
               data_o    <= 1'b1;
            end
         end else begin
            case (state_reg)
               IDLE: begin
                  data_o <= 1'b1;
                  if (!atn_mode_reg && listening && !clk_s) begin
                     state_reg <= WAIT_REL;
                     data_o    <= 1'b0;
                  end
               end
               WAIT_REL: begin
                  data_o <= 1'b0;
                  // Command bytes are always accepted; data waits for the core.
                  if (clk_s && (atn_mode_reg || rx_ready)) begin
                     state_reg <= READY;
                     data_o    <= 1'b1;
                     timer_reg <= 16'd0;
                  end
               end
               READY: begin
                  timer_reg <= timer_reg + 16'd1;
                  if (!clk_s) begin
                     state_reg   <= BIT_LO;
                     eoi_reg     <= 1'b0;
                     bit_cnt_reg <= 4'd0;
                  end else if (timer_reg == EOI_TICKS - 16'd1) begin
                     state_reg <= EOI_ACK;
                     eoi_reg   <= 1'b1;
                     timer_reg <= 16'd0;
                     data_o    <= 1'b0;
                  end
               end
               EOI_ACK: begin
                  timer_reg <= timer_reg + 16'd1;
                  if (timer_reg == HOLD_TICKS - 16'd1) begin
                     state_reg <= EOI_WAIT;
                     data_o    <= 1'b1;
                  end
               end
               EOI_WAIT: begin
                  if (!clk_s) begin
                     state_reg   <= BIT_LO;
                     bit_cnt_reg <= 4'd0;
                  end
               end
               BIT_LO: begin
                  if (clk_rise) begin
                     shift_reg[bit_cnt_reg[2:0]] <= dat_s;
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     state_reg   <= BIT_HI;
                  end
               end
               BIT_HI: begin
                  if (clk_fall) begin
                     if (bit_cnt_reg == 4'd8) begin
                        state_reg <= ACK;
                        data_o    <= 1'b0;
                     end else begin
                        state_reg <= BIT_LO;
                     end
                  end
               end
               ACK: begin
                  rx_valid    <= 1'b1;
                  rx_data     <= shift_reg;
                  rx_eoi      <= eoi_reg;
                  rx_atn      <= atn_mode_reg;
                  bit_cnt_reg <= 4'd0;
                  if (atn_mode_reg) begin
                     if (shift_reg == LISTEN_CMD)
                        listening <= 1'b1;
                     else if (shift_reg == 8'h3F)
                        listening <= 1'b0;
                     // 0x40..0x5F: talk to us, or untalk / talk to someone else.
                     if (shift_reg[7:5] == 3'b010)
                        talking <= (shift_reg[4:0] == DEV);
                     if ((shift_reg[7:5] == 3'b011 || shift_reg[7:5] == 3'b111) &&
                         (listening || talking)) begin
                        channel <= shift_reg[3:0];
                        sec_cmd <= shift_reg[7:4];
                     end
                  end
                  if (eoi_reg && !atn_mode_reg) begin
                     state_reg <= IDLE;
                     data_o    <= 1'b1;
                  end else begin
                     state_reg <= WAIT_REL;
                     data_o    <= 1'b0;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  data_o    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iec_listener.sv
// Bench for iec_listener: drives the controller side of the bus and checks the
// received-byte stream against a scoreboard plus address/channel flags.
module tb_iec_listener;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       atn_i = 1'b1;
   logic       clock_i = 1'b1;
   logic       data_i = 1'b1;
   logic       rx_ready = 1'b1;
   logic       data_o, clock_o, rx_valid, rx_eoi, rx_atn, listening, talking;
   logic [7:0] rx_data;
   logic [3:0] channel, sec_cmd;

   int vectors = 0;
   int miscompares = 0;
   int rx_seen = 0;
   int rx_extra = 0;
   logic [9:0] sb_q[$];

   iec_listener #(.DEVICE(8), .CLKS_PER_US(8), .EOI_TIMEOUT_US(200), .EOI_HOLD_US(60)) dut (
      .clk(clk), .reset(reset), .atn_i(atn_i), .clock_i(clock_i), .data_i(data_i),
      .data_o(data_o), .clock_o(clock_o), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_eoi(rx_eoi), .rx_atn(rx_atn), .rx_ready(rx_ready), .listening(listening),
      .talking(talking), .channel(channel), .sec_cmd(sec_cmd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pop the scoreboard on every received byte: {atn, eoi, data}.
   always @(negedge clk) begin
      if (!reset && rx_valid === 1'b1) begin
         rx_seen++;
         $display("rx byte %02h eoi=%0d atn=%0d", rx_data, rx_eoi, rx_atn);
         if (sb_q.size() == 0)
            rx_extra++;
         else
            chk("rx_byte", 16'({rx_atn, rx_eoi, rx_data}), 16'(sb_q.pop_front()));
      end
   end

   task automatic wait_data(input logic v, input int lim, input string tag);
      int n;
      n = 0;
      while (data_o !== v && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 16'(data_o), 16'(v));
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         clock_i = 1'b0;
         data_i  = b[i];
         repeat (4) @(negedge clk);
         clock_i = 1'b1;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic eoi, input logic atn, input logic exp);
      int w;
      if (exp) sb_q.push_back({atn, eoi, b});
      clock_i = 1'b1;
      wait_data(1'b1, 20, "ready_release");
      if (eoi) begin
         wait_data(1'b0, 2500, "eoi_start");
         w = 0;
         while (data_o === 1'b0 && w < 1000) begin
            @(negedge clk);
            w++;
         end
         chk("eoi_hold", 16'(w), 16'd480);
      end
      send_bits(b, 8);
      clock_i = 1'b0;
      data_i  = 1'b1;
      if (eoi) begin
         // Talker is done: let CLK go again before the listener returns to idle.
         repeat (2) @(negedge clk);
         clock_i = 1'b1;
         repeat (4) @(negedge clk);
      end else begin
         wait_data(1'b0, 20, "frame_ack");
         repeat (2) @(negedge clk);
      end
   endtask

   initial begin
      repeat (5) @(negedge clk);
      chk("rst_data_o", 16'(data_o), 16'd1);
      chk("rst_clock_o", 16'(clock_o), 16'd1);
      chk("rst_rx_data", 16'(rx_data), 16'h0);
      chk("rst_rx_valid", 16'(rx_valid), 16'd0);
      chk("rst_flags", 16'({listening, talking, rx_eoi, rx_atn}), 16'h0);
      chk("rst_chan", 16'({channel, sec_cmd}), 16'h0);
      reset = 1'b0;
      repeat (10000) @(negedge clk);
      chk("idle_data_o", 16'(data_o), 16'd1);
      chk("idle_listen", 16'(listening), 16'd0);
      chk("idle_rx", 16'(rx_seen), 16'd0);

      // Address as listener, open channel 15.
      atn_i = 1'b0;
      clock_i = 1'b0;
      wait_data(1'b0, 3, "atn_fall_ack");
      send_byte(8'h28, 1'b0, 1'b1, 1'b1);
      send_byte(8'h6F, 1'b0, 1'b1, 1'b1);
      chk("listen_set", 16'(listening), 16'd1);
      chk("talk_clear", 16'(talking), 16'd0);
      chk("channel_f", 16'(channel), 16'hF);
      chk("sec_cmd_6", 16'(sec_cmd), 16'h6);
      atn_i = 1'b1;
      repeat (10) @(negedge clk);
      chk("atn_rel_listen", 16'(data_o), 16'd0);
      chk("rx_count_cmd", 16'(rx_seen), 16'd2);

      // Core not ready holds DATA low.
      rx_ready = 1'b0;
      clock_i = 1'b1;
      repeat (50) @(negedge clk);
      chk("not_ready_hold", 16'(data_o), 16'd0);
      rx_ready = 1'b1;
      wait_data(1'b1, 3, "ready_release_fast");
      send_byte(8'h41, 1'b0, 1'b0, 1'b1);
      send_byte(8'h42, 1'b1, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      chk("post_eoi_release", 16'(data_o), 16'd1);
      chk("rx_count_data", 16'(rx_seen), 16'd4);

      // ATN in the middle of a byte aborts it; next byte is a command.
      clock_i = 1'b0;
      wait_data(1'b0, 10, "listen_hold");
      clock_i = 1'b1;
      wait_data(1'b1, 20, "partial_ready");
      send_bits(8'hA5, 4);
      atn_i = 1'b0;
      clock_i = 1'b0;
      wait_data(1'b0, 5, "atn_abort_ack");
      send_byte(8'h3F, 1'b0, 1'b1, 1'b1);
      chk("unlisten", 16'(listening), 16'd0);
      atn_i = 1'b1;
      repeat (10) @(negedge clk);
      chk("unlisten_release", 16'(data_o), 16'd1);
      chk("rx_count_abort", 16'(rx_seen), 16'd5);

      // Talk/untalk, secondary gating, other device's listen address.
      atn_i = 1'b0;
      clock_i = 1'b0;
      wait_data(1'b0, 3, "atn_fall_2");
      send_byte(8'h48, 1'b0, 1'b1, 1'b1);
      chk("talk_set", 16'(talking), 16'd1);
      send_byte(8'h62, 1'b0, 1'b1, 1'b1);
      chk("talk_sec", 16'({sec_cmd, channel}), 16'h62);
      send_byte(8'h5F, 1'b0, 1'b1, 1'b1);
      chk("untalk", 16'(talking), 16'd0);
      send_byte(8'h29, 1'b0, 1'b1, 1'b1);
      chk("other_dev", 16'(listening), 16'd0);
      send_byte(8'h65, 1'b0, 1'b1, 1'b1);
      chk("sec_ignored", 16'({sec_cmd, channel}), 16'h62);
      atn_i = 1'b1;
      repeat (10) @(negedge clk);
      chk("other_release", 16'(data_o), 16'd1);
      send_bits(8'h55, 8);
      clock_i = 1'b0;
      repeat (20) @(negedge clk);
      chk("other_idle", 16'(data_o), 16'd1);
      chk("rx_count_final", 16'(rx_seen), 16'd10);
      chk("sb_drained", 16'(sb_q.size()), 16'd0);
      chk("rx_spurious", 16'(rx_extra), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
